matrix_link_rx: RTL and testbench

- Receive-side counterpart of the FPGA matrix output path. Deserialises the multi-lane SPI stream (one shared spi_clk, CHANNEL_NUMBER mosi lanes) into parallel words.
- Decodes the serial column-select shift-register interface (ser_clk/ser_data/ser_stcp/ser_n_enable) into a column index.
- Used for FPGA loopback self-test and as a synthesizable link monitor. All inputs are asynchronous to clk and oversampled.

---
 rtl/matrix_link_pkg.sv | 19 +
 rtl/matrix_link_rx_edge_sync.sv | 40 ++++
 rtl/matrix_link_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_matrix_link_rx.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_link_pkg.sv
// Shared types and width helpers for the matrix link receiver.
package matrix_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Width of a column index; a single column still needs one bit.
    function automatic int col_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value n.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/matrix_link_rx_edge_sync.sv
// Two-flop synchroniser plus history flop with rising-edge detect.
module edge_sync #(
    parameter int       W       = 1,
    parameter logic     RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise
);

    logic [W-1:0] ff1_q, ff1_d;
    logic [W-1:0] ff2_q, ff2_d;
    logic [W-1:0] hist_q, hist_d;

    // Next-state of the chain: each flop takes its predecessor.
    always_comb begin
        ff1_d  = din;
        ff2_d  = ff1_q;
        hist_d = ff2_q;
    end

    // Synchroniser and history registers; reset value chosen so no edge fires on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q  <= {W{RST_VAL}};
            ff2_q  <= {W{RST_VAL}};
            hist_q <= {W{RST_VAL}};
        end else begin
            ff1_q  <= ff1_d;
            ff2_q  <= ff2_d;
            hist_q <= hist_d;
        end
    end

    assign sync = ff2_q;
    assign rise = ff2_q & ~hist_q;

endmodule

// File: rtl/matrix_link_rx.sv
// Receive side of the matrix link: multi-lane SPI deserialiser and
// column shift-chain decoder, both oversampled from asynchronous pins.
module matrix_link_rx
    import matrix_link_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 3,
    parameter int SPI_SIZE       = 8,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int COLUMN_NUMBER  = 16,
    parameter int TIMEOUT        = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  spi_clk,
    input  logic [CHANNEL_NUMBER-1:0]             spi_mosi,
    input  logic                                  ser_clk,
    input  logic                                  ser_data,
    input  logic                                  ser_stcp,
    input  logic                                  ser_n_enable,
    output logic [SPI_SIZE-1:0]                   data_out [CHANNEL_NUMBER],
    output logic                                  data_valid,
    output logic                                  word_abort,
    output logic [col_idx_w(COLUMN_NUMBER)-1:0]   column_index,
    output logic                                  column_valid,
    output logic                                  column_strobe,
    output logic                                  new_image,
    output logic                                  extra_bit_out,
    output logic                                  output_enabled
);

    localparam int CIW   = col_idx_w(COLUMN_NUMBER);
    localparam int CNT_W = cnt_w(SPI_SIZE);
    localparam int TMO_W = cnt_w(TIMEOUT);

    // ---------------- synchronisers ----------------
    logic                      sclk_sync, sclk_rise;
    logic [CHANNEL_NUMBER-1:0] mosi_sync, mosi_rise;
    logic                      cclk_sync, cclk_rise;
    logic                      cdat_sync, cdat_rise;
    logic                      stcp_sync, stcp_rise;
    logic                      nen_sync, nen_rise;

    edge_sync #(.W(1)) u_sync_spi_clk (
        .clk(clk), .rst_n(rst_n), .din(spi_clk), .sync(sclk_sync), .rise(sclk_rise));
    edge_sync #(.W(CHANNEL_NUMBER)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi), .sync(mosi_sync), .rise(mosi_rise));
    edge_sync #(.W(1)) u_sync_ser_clk (
        .clk(clk), .rst_n(rst_n), .din(ser_clk), .sync(cclk_sync), .rise(cclk_rise));
    edge_sync #(.W(1)) u_sync_ser_data (
        .clk(clk), .rst_n(rst_n), .din(ser_data), .sync(cdat_sync), .rise(cdat_rise));
    edge_sync #(.W(1)) u_sync_ser_stcp (
        .clk(clk), .rst_n(rst_n), .din(ser_stcp), .sync(stcp_sync), .rise(stcp_rise));
    // Resets to "disabled" so output_enabled reads 0 while in reset.
    edge_sync #(.W(1), .RST_VAL(1'b1)) u_sync_ser_nen (
        .clk(clk), .rst_n(rst_n), .din(ser_n_enable), .sync(nen_sync), .rise(nen_rise));

    // Level/edge taps that the decoders do not need.
    logic unused_taps;
    assign unused_taps = ^{sclk_sync, mosi_rise, cclk_sync, cdat_rise, stcp_sync, nen_rise};

    assign output_enabled = ~nen_sync;

    // ---------------- SPI deserialiser ----------------
    rx_state_t                                state_q, state_d;
    logic [CNT_W-1:0]                         bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]                         tmo_q, tmo_d;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  shreg_q, shreg_d, shifted;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  dout_q, dout_d;
    logic                                     copy_q, copy_d;
    logic                                     dvalid_q, dvalid_d;
    logic                                     abort_q, abort_d;

    // All lanes shift in parallel; direction decides where the new bit lands.
    always_comb begin
        shifted = shreg_q;
        for (int l = 0; l < CHANNEL_NUMBER; l++) begin
            if (MSB_FIRST)
                shifted[l] = {shreg_q[l][SPI_SIZE-2:0], mosi_sync[l]};
            else
                shifted[l] = {mosi_sync[l], shreg_q[l][SPI_SIZE-1:1]};
        end
    end

    // Word FSM: the copy to data_out lags the last bit by one cycle, so a
    // rise in the copy cycle is taken as bit 0 of the next word.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        copy_d    = 1'b0;
        dvalid_d  = 1'b0;
        abort_d   = 1'b0;
        if (copy_q) begin
            dout_d   = shreg_q;
            dvalid_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tmo_d     = '0;
                if (sclk_rise) begin
                    shreg_d   = shifted;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (sclk_rise) begin
                    shreg_d = shifted;
                    tmo_d   = '0;
                    if (bit_cnt_q == CNT_W'(SPI_SIZE - 1)) begin
                        copy_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    abort_d   = 1'b1;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SPI state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            copy_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            copy_q    <= copy_d;
            dvalid_q  <= dvalid_d;
            abort_q   <= abort_d;
        end
    end

    // Present the packed word registers on the unpacked output port.
    always_comb begin
        for (int l = 0; l < CHANNEL_NUMBER; l++) data_out[l] = dout_q[l];
    end

    assign data_valid = dvalid_q;
    assign word_abort = abort_q;

    // ---------------- column chain ----------------
    logic [COLUMN_NUMBER:0] chain_q, chain_d;
    logic [COLUMN_NUMBER:0] stor_q, stor_d;
    logic                   latch_q, latch_d;
    logic [CIW-1:0]         idx_q, idx_d, low_idx;
    logic                   cvalid_q, cvalid_d;
    logic                   strobe_q, strobe_d;
    logic                   newimg_q, newimg_d;
    logic                   extra_q, extra_d;

    // Lowest set column bit, 0 when the pattern is empty.
    always_comb begin
        low_idx = '0;
        for (int i = COLUMN_NUMBER - 1; i >= 0; i--)
            if (stor_q[i]) low_idx = CIW'(i);
    end

    // Storage samples the chain before any same-cycle shift; decode follows a cycle later.
    always_comb begin
        chain_d  = chain_q;
        stor_d   = stor_q;
        latch_d  = 1'b0;
        idx_d    = idx_q;
        cvalid_d = cvalid_q;
        extra_d  = extra_q;
        strobe_d = 1'b0;
        newimg_d = 1'b0;
        if (stcp_rise) begin
            stor_d  = chain_q;
            latch_d = 1'b1;
        end
        if (cclk_rise)
            chain_d = {chain_q[COLUMN_NUMBER-1:0], cdat_sync};
        if (latch_q) begin
            idx_d    = low_idx;
            cvalid_d = $onehot(stor_q[COLUMN_NUMBER-1:0]);
            extra_d  = stor_q[COLUMN_NUMBER];
            strobe_d = 1'b1;
            newimg_d = cvalid_d && (low_idx == '0);
        end
    end

    // Column chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q  <= '0;
            stor_q   <= '0;
            latch_q  <= 1'b0;
            idx_q    <= '0;
            cvalid_q <= 1'b0;
            extra_q  <= 1'b0;
            strobe_q <= 1'b0;
            newimg_q <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            stor_q   <= stor_d;
            latch_q  <= latch_d;
            idx_q    <= idx_d;
            cvalid_q <= cvalid_d;
            extra_q  <= extra_d;
            strobe_q <= strobe_d;
            newimg_q <= newimg_d;
        end
    end

    assign column_index  = idx_q;
    assign column_valid  = cvalid_q;
    assign column_strobe = strobe_q;
    assign new_image     = newimg_q;
    assign extra_bit_out = extra_q;

endmodule

// File: tb/tb_matrix_link_rx.sv
// Randomised self-checking bench for matrix_link_rx against a word/pattern level model.
module tb_matrix_link_rx;

    localparam int CH  = 3;
    localparam int SZ  = 8;
    localparam bit MSB = 1'b1;
    localparam int COL = 16;
    localparam int TMO = 64;

    typedef logic [CH-1:0][SZ-1:0] word_t;
    typedef struct {
        logic [3:0] idx;
        logic       v;
        logic       ex;
        logic       ni;
    } col_ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_clk = 1'b0;
    logic [CH-1:0] spi_mosi = '0;
    logic          ser_clk = 1'b0, ser_data = 1'b0, ser_stcp = 1'b0, ser_n_enable = 1'b1;
    logic [SZ-1:0] data_out [CH];
    logic          data_valid, word_abort;
    logic [3:0]    column_index;
    logic          column_valid, column_strobe, new_image, extra_bit_out, output_enabled;

    matrix_link_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .MSB_FIRST(MSB),
                     .COLUMN_NUMBER(COL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp),
        .ser_n_enable(ser_n_enable), .data_out(data_out), .data_valid(data_valid),
        .word_abort(word_abort), .column_index(column_index), .column_valid(column_valid),
        .column_strobe(column_strobe), .new_image(new_image),
        .extra_bit_out(extra_bit_out), .output_enabled(output_enabled));

    always #5 clk = ~clk;

    int      n_cmp = 0, n_err = 0;
    int      cyc = 0;
    int      last_rise_cyc = 0;
    word_t   rx_q[$];
    int      abort_cyc[$];
    col_ev_t col_q[$];
    int      stray_ni = 0;
    logic [COL:0] chain_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        word_t w;
        col_ev_t e;
        if (data_valid) begin
            for (int l = 0; l < CH; l++) w[l] = data_out[l];
            rx_q.push_back(w);
        end
        if (word_abort) abort_cyc.push_back(cyc);
        if (column_strobe) begin
            e.idx = column_index; e.v = column_valid; e.ex = extra_bit_out; e.ni = new_image;
            col_q.push_back(e);
        end
        if (new_image && !column_strobe) stray_ni++;
    end

    // Column decode from the rules: lowest set column, valid when exactly one is set.
    function automatic col_ev_t model_col(input logic [COL:0] s);
        col_ev_t e;
        int ones = 0;
        e.idx = 0;
        for (int i = COL - 1; i >= 0; i--) if (s[i]) begin e.idx = 4'(i); ones++; end
        e.v  = (ones == 1);
        e.ex = s[COL];
        e.ni = e.v && (e.idx == 0);
        return e;
    endfunction

    // Drive nbits of a word on all lanes; spi_clk period is 2*half clk.
    task automatic send_word(input word_t w, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            for (int l = 0; l < CH; l++) spi_mosi[l] = MSB ? w[l][SZ-1-i] : w[l][i];
            repeat (half - 1) @(negedge clk);
            spi_clk = 1'b1;
            last_rise_cyc = cyc;
            repeat (half) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 40 && rx_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        @(negedge clk);
        ser_data = b;
        repeat (2) @(negedge clk);
        ser_clk = 1'b1;
        repeat (2) @(negedge clk);
        ser_clk = 1'b0;
        chain_m = {chain_m[COL-1:0], b};
    endtask

    task automatic shift_pattern(input logic [COL:0] p);
        for (int i = COL; i >= 0; i--) shift_bit(p[i]);
    endtask

    task automatic strobe();
        repeat (2) @(negedge clk);
        ser_stcp = 1'b1;
        repeat (2) @(negedge clk);
        ser_stcp = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data_valid, word_abort, column_index, column_valid, column_strobe,
             new_image, extra_bit_out, output_enabled} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {data_valid, word_abort, column_index,
                     column_valid, column_strobe, new_image, extra_bit_out, output_enabled});
        end
        for (int l = 0; l < CH; l++) begin
            n_cmp++;
            if (data_out[l] !== '0) begin
                n_err++; $display("FAIL reset_data_out[%0d]: got %h want 00", l, data_out[l]);
            end
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_word();
        word_t w;
        w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hFF;
        rx_q.delete(); abort_cyc.delete();
        send_word(w, SZ, 4);
        wait_words(1);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rx_q.size() !== 1) begin
            n_err++; $display("FAIL word_count: got %0d want 1", rx_q.size());
        end else begin
            n_cmp++;
            if (rx_q[0] !== w) begin n_err++; $display("FAIL word_value: got %h want %h", rx_q[0], w); end
        end
        n_cmp++;
        if (abort_cyc.size() !== 0) begin
            n_err++; $display("FAIL word_no_abort: got %0d aborts want 0", abort_cyc.size());
        end
    endtask

    task automatic test_random_words();
        word_t exp_q[$];
        word_t w;
        rx_q.delete();
        for (int k = 0; k < 6; k++) begin
            w = word_t'({$urandom, $urandom});
            exp_q.push_back(w);
            send_word(w, SZ, 2 + (k % 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_words(exp_q.size());
        n_cmp++;
        if (rx_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_cmp++;
                if (rx_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL rand_word[%0d]: got %h want %h", k, rx_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        word_t a, b;
        a = {CH{8'h01}}; b = {CH{8'h80}};
        rx_q.delete();
        send_word(a, SZ, 2);
        send_word(b, SZ, 2);
        wait_words(2);
        n_cmp++;
        if (rx_q.size() !== 2) begin
            n_err++; $display("FAIL b2b_count: got %0d want 2", rx_q.size());
        end else begin
            n_cmp++;
            if (rx_q[0] !== a || rx_q[1] !== b) begin
                n_err++; $display("FAIL b2b_order: got %h,%h want %h,%h", rx_q[0], rx_q[1], a, b);
            end
        end
    endtask

    task automatic test_timeout();
        word_t p, w;
        p = word_t'({$urandom, $urandom});
        w = {CH{8'h55}};
        rx_q.delete(); abort_cyc.delete();
        send_word(p, 5, 4);
        repeat (100) @(negedge clk);
        n_cmp++;
        if (abort_cyc.size() !== 1) begin
            n_err++; $display("FAIL abort_count: got %0d want 1", abort_cyc.size());
        end else begin
            // 3 clk from pin edge to registered rise, then TIMEOUT cycles to the pulse.
            n_cmp++;
            if (abort_cyc[0] - last_rise_cyc !== 3 + TMO) begin
                n_err++; $display("FAIL abort_timing: got %0d want %0d",
                                  abort_cyc[0] - last_rise_cyc, 3 + TMO);
            end
        end
        n_cmp++;
        if (rx_q.size() !== 0) begin n_err++; $display("FAIL abort_no_valid: got %0d want 0", rx_q.size()); end
        send_word(w, SZ, 4);
        wait_words(1);
        n_cmp++;
        if (rx_q.size() !== 1 || rx_q[0] !== w) begin
            n_err++; $display("FAIL after_abort_word: got n=%0d want %h", rx_q.size(), w);
        end
    endtask

    task automatic test_column_basic();
        col_ev_t e;
        logic [COL:0] p;
        p = '0; p[COL] = 1'b1; p[0] = 1'b1;
        col_q.delete();
        shift_pattern(p);
        strobe();
        e = model_col(chain_m);
        n_cmp++;
        if (col_q.size() !== 1 || col_q[0] !== e || e.ni !== 1'b1) begin
            n_err++; $display("FAIL col_first: got n=%0d idx=%0d v=%b ex=%b ni=%b want idx=0 v=1 ex=1 ni=1",
                              col_q.size(), column_index, column_valid, extra_bit_out, col_q.size() > 0 ? col_q[0].ni : 1'bx);
        end
        col_q.delete();
        shift_bit(1'b0);
        strobe();
        e = model_col(chain_m);
        n_cmp++;
        if (col_q.size() !== 1 || col_q[0] !== e || e.idx !== 4'd1 || e.ni !== 1'b0) begin
            n_err++; $display("FAIL col_second: got n=%0d idx=%0d ni=%b want idx=1 ni=0",
                              col_q.size(), column_index, new_image);
        end
    endtask

    task automatic test_column_multi();
        logic [COL:0] p;
        p = '0; p[3] = 1'b1; p[7] = 1'b1;
        col_q.delete();
        shift_pattern(p);
        strobe();
        n_cmp++;
        if (col_q.size() !== 1 || col_q[0].v !== 1'b0 || col_q[0].idx !== 4'd3 || col_q[0].ni !== 1'b0) begin
            n_err++; $display("FAIL col_multi: got n=%0d idx=%0d v=%b want n=1 idx=3 v=0",
                              col_q.size(), column_index, column_valid);
        end
    endtask

    task automatic test_column_random();
        col_ev_t e;
        logic [COL:0] p;
        for (int k = 0; k < 4; k++) begin
            p = (k % 2) ? (17'(1) << $urandom_range(0, COL)) : 17'($urandom);
            col_q.delete();
            shift_pattern(p);
            strobe();
            e = model_col(chain_m);
            n_cmp++;
            if (col_q.size() !== 1 || col_q[0] !== e) begin
                n_err++; $display("FAIL col_rand[%0d]: got idx=%0d v=%b ex=%b want idx=%0d v=%b ex=%b",
                                  k, column_index, column_valid, extra_bit_out, e.idx, e.v, e.ex);
            end
        end
    endtask

    // ser_clk and ser_stcp rising together: storage sees the chain before the shift.
    task automatic test_simultaneous();
        col_ev_t e_pre, e_post;
        logic b;
        b = 1'($urandom);
        col_q.delete();
        e_pre = model_col(chain_m);
        @(negedge clk);
        ser_data = b;
        repeat (2) @(negedge clk);
        ser_clk = 1'b1; ser_stcp = 1'b1;
        repeat (2) @(negedge clk);
        ser_clk = 1'b0; ser_stcp = 1'b0;
        chain_m = {chain_m[COL-1:0], b};
        repeat (10) @(negedge clk);
        strobe();
        e_post = model_col(chain_m);
        n_cmp++;
        if (col_q.size() !== 2 || col_q[0] !== e_pre || col_q[1] !== e_post) begin
            n_err++; $display("FAIL col_simul: got n=%0d idx=%0d want pre idx=%0d post idx=%0d",
                              col_q.size(), column_index, e_pre.idx, e_post.idx);
        end
        n_cmp++;
        if (stray_ni !== 0) begin n_err++; $display("FAIL new_image_stray: got %0d want 0", stray_ni); end
    endtask

    task automatic test_output_enable();
        ser_n_enable = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (output_enabled !== 1'b1) begin n_err++; $display("FAIL oe_on: got %b want 1", output_enabled); end
        ser_n_enable = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (output_enabled !== 1'b0) begin n_err++; $display("FAIL oe_off: got %b want 0", output_enabled); end
    endtask

    task automatic test_reset_mid_word();
        word_t p, w;
        p = word_t'({$urandom, $urandom});
        w = {CH{8'h0F}};
        send_word(p, 4, 4);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({data_valid, word_abort, column_strobe, column_valid, new_image, extra_bit_out,
             column_index, output_enabled} !== 10'd0 || data_out[0] !== '0) begin
            n_err++; $display("FAIL midreset_outputs: dv=%b ab=%b cs=%b d0=%h want all 0",
                              data_valid, word_abort, column_strobe, data_out[0]);
        end
        rst_n = 1'b1;
        chain_m = '0;
        rx_q.delete(); abort_cyc.delete(); col_q.delete();
        repeat (100) @(negedge clk);
        n_cmp++;
        if (rx_q.size() + abort_cyc.size() + col_q.size() !== 0) begin
            n_err++; $display("FAIL midreset_no_pulses: got %0d pulses want 0",
                              rx_q.size() + abort_cyc.size() + col_q.size());
        end
        send_word(w, SZ, 4);
        wait_words(1);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rx_q.size() !== 1 || rx_q[0] !== w) begin
            n_err++; $display("FAIL midreset_word: got n=%0d want one %h", rx_q.size(), w);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_random_words();
        test_back_to_back();
        test_timeout();
        test_column_basic();
        test_column_multi();
        test_column_random();
        test_simultaneous();
        test_output_enable();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
